// File: rtl/fpu_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fpu_seq : multi-cycle FDIV/SQRT/FMUL sequencer over float units  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fpu_seq #(
  parameter int FINV_LAT = 1,
  parameter int SQRT_LAT = 1,
  parameter int FMUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] fs,
  input  logic [31:0] ft,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic [31:0] u_fs,
  output logic [31:0] u_ft,
  input  logic [31:0] finv_d,
  input  logic [31:0] sqrt_d,
  input  logic [31:0] fmul_d,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam int MAX_LAT = (FINV_LAT > SQRT_LAT)
                         ? ((FINV_LAT > FMUL_LAT) ? FINV_LAT : FMUL_LAT)
                         : ((SQRT_LAT > FMUL_LAT) ? SQRT_LAT : FMUL_LAT);
  localparam int CW = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  localparam logic [5:0]    OP_FMUL = 6'b000010;
  localparam logic [5:0]    OP_FDIV = 6'b000011;
  localparam logic [5:0]    OP_SQRT = 6'b000100;
  localparam logic [CW-1:0] C_FINV  = CW'(FINV_LAT);
  localparam logic [CW-1:0] C_SQRT  = CW'(SQRT_LAT);
  localparam logic [CW-1:0] C_FMUL  = CW'(FMUL_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INV  = 2'd1,
    S_MUL  = 2'd2,
    S_SQ   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   u_fs_q, u_fs_d;
  logic [31:0]   u_ft_q, u_ft_d;
  logic [31:0]   result_q, result_d;
  logic [4:0]    rd_q, rd_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  // An illegal op is reported one edge after it is sampled, aligning its
  // done/err pulse with the single-edge latency of the fastest legal op.
  logic          bad_q, bad_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    u_fs_d   = u_fs_q;
    u_ft_d   = u_ft_q;
    result_d = result_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    bad_d    = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      if (bad_q) begin
        done_d   = 1'b1;
        err_d    = 1'b1;
        result_d = '0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            u_fs_d = fs;
            u_ft_d = ft;
            rd_d   = rd_in;
            case (op)
              OP_FDIV: begin
                state_d = S_INV;
                cnt_d   = C_FINV;
              end
              OP_SQRT: begin
                state_d = S_SQ;
                cnt_d   = C_SQRT;
              end
              OP_FMUL: begin
                state_d = S_MUL;
                cnt_d   = C_FMUL;
              end
              default: bad_d = 1'b1;
            endcase
          end
        end
        S_INV: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            // Reciprocal replaces the B operand so MUL computes fs * (1/ft).
            u_ft_d  = finv_d;
            state_d = S_MUL;
            cnt_d   = C_FMUL;
          end
        end
        S_MUL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            result_d = fmul_d;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_SQ: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            result_d = sqrt_d;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      u_fs_q   <= '0;
      u_ft_q   <= '0;
      result_q <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      u_fs_q   <= u_fs_d;
      u_ft_q   <= u_ft_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      err_q    <= err_d;
      bad_q    <= bad_d;
    end
  end

  assign u_fs   = u_fs_q;
  assign u_ft   = u_ft_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_seq.sv
`default_nettype none
// tb_fpu_seq: randomized bench for fpu_seq with delayed models of the float units.
module tb_fpu_seq;

  localparam int FINV_LAT = 1;
  localparam int SQRT_LAT = 3;
  localparam int FMUL_LAT = 0;
  localparam logic [5:0] OP_FMUL = 6'b000010;
  localparam logic [5:0] OP_FDIV = 6'b000011;
  localparam logic [5:0] OP_SQRT = 6'b000100;
  localparam logic [5:0] OP_BAD  = 6'b000101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] fs = '0;
  logic [31:0] ft = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] u_fs, u_ft, finv_d, sqrt_d, fmul_d, result;
  logic        busy, done, err;
  logic [4:0]  rd_out;

  int n_pass = 0;
  int n_total = 0;

  fpu_seq #(.FINV_LAT(FINV_LAT), .SQRT_LAT(SQRT_LAT), .FMUL_LAT(FMUL_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .fs(fs), .ft(ft),
    .rd_in(rd_in), .flush(flush), .u_fs(u_fs), .u_ft(u_ft),
    .finv_d(finv_d), .sqrt_d(sqrt_d), .fmul_d(fmul_d), .busy(busy),
    .done(done), .err(err), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // IEEE single <-> real conversion (normal numbers and zero only).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] m24;
    int e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    m   = {1'b1, d[51:0]};
    m24 = {1'b0, m[52:29]};
    e   = int'(d[62:52]) - 1023 + 127;
    if (m[28] && ((|m[27:0]) || m[29])) m24 = m24 + 25'd1;
    if (m24[24]) begin
      m24 = m24 >> 1;
      e   = e + 1;
    end
    return {d[63], e[7:0], m24[22:0]};
  endfunction

  function automatic logic [31:0] m_inv(input logic [31:0] x);
    return r2f(1.0 / f2r(x));
  endfunction
  function automatic logic [31:0] m_sqrt(input logic [31:0] x);
    return r2f($sqrt(f2r(x)));
  endfunction
  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] rnd_f(input bit pos);
    logic s;
    s = pos ? 1'b0 : 1'($urandom_range(0, 1));
    return {s, 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // External units: result is the function of the operand seen LAT edges earlier.
  logic [31:0] w_inv, w_sq, w_mul;
  logic [31:0] inv_h [1:3];
  logic [31:0] sq_h  [1:3];
  logic [31:0] mul_h [1:3];
  assign w_inv = m_inv(u_ft);
  assign w_sq  = m_sqrt(u_fs);
  assign w_mul = m_mul(u_fs, u_ft);
  always @(posedge clk) begin
    inv_h[1] <= w_inv; inv_h[2] <= inv_h[1]; inv_h[3] <= inv_h[2];
    sq_h[1]  <= w_sq;  sq_h[2]  <= sq_h[1];  sq_h[3]  <= sq_h[2];
    mul_h[1] <= w_mul; mul_h[2] <= mul_h[1]; mul_h[3] <= mul_h[2];
  end
  assign finv_d = (FINV_LAT == 0) ? w_inv : inv_h[(FINV_LAT == 0) ? 1 : FINV_LAT];
  assign sqrt_d = (SQRT_LAT == 0) ? w_sq  : sq_h[(SQRT_LAT == 0) ? 1 : SQRT_LAT];
  assign fmul_d = (FMUL_LAT == 0) ? w_mul : mul_h[(FMUL_LAT == 0) ? 1 : FMUL_LAT];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to its done pulse (lat = -1 on timeout).
  task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, output int lat, output int nbusy,
                        output logic [31:0] res, output logic [4:0] tag, output logic e,
                        output logic [31:0] ft_seen);
    op = o; fs = a; ft = b; rd_in = r; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; nbusy = 0; ft_seen = '0;
    while (!done && lat < 64) begin
      if (busy) begin
        nbusy++;
        ft_seen = u_ft;
      end
      tick();
      lat++;
    end
    if (!done) lat = -1;
    res = result; tag = rd_out; e = err;
  endtask

  task automatic test_reset();
    int lat, nb, nd;
    logic [31:0] res, fsn;
    logic [4:0] tag;
    logic e;
    #2;
    n_total++; if ({u_fs, u_ft, result, rd_out, done, err, busy} !== '0) $display("FAIL reset_init: outputs %h/%h/%h rd=%0d d=%b e=%b b=%b, want all 0", u_fs, u_ft, result, rd_out, done, err, busy); else n_pass++;
    #2 rst = 1'b0;
    tick();
    op = OP_FDIV; fs = 32'h40C00000; ft = 32'h40400000; rd_in = 5'd7; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL reset_pre_busy: busy=%b want 1", busy); else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_total++; if ({u_fs, u_ft, result, rd_out, done, err, busy} !== '0) $display("FAIL reset_async: outputs %h/%h/%h rd=%0d d=%b e=%b b=%b, want all 0", u_fs, u_ft, result, rd_out, done, err, busy); else n_pass++;
    tick();
    #3 rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) nd++;
    end
    n_total++; if (nd !== 0) $display("FAIL reset_no_done: saw %0d done, want 0", nd); else n_pass++;
    run_op(OP_FMUL, 32'h40000000, 32'h40400000, 5'd2, lat, nb, res, tag, e, fsn);
    n_total++; if (lat !== FMUL_LAT + 1) $display("FAIL reset_fmul_lat: got %0d want %0d", lat, FMUL_LAT + 1); else n_pass++;
    n_total++; if (res !== 32'h40C00000) $display("FAIL reset_fmul_res: got %h want 40c00000", res); else n_pass++;
  endtask

  task automatic test_fdiv();
    int lat, nb;
    logic [31:0] res, fsn, a, b, exp_r;
    logic [4:0] tag;
    logic e;
    tick();
    run_op(OP_FDIV, 32'h40C00000, 32'h40400000, 5'd5, lat, nb, res, tag, e, fsn);
    n_total++; if (nb !== 3) $display("FAIL fdiv_busy: busy cycles %0d want 3", nb); else n_pass++;
    n_total++; if (fsn !== 32'h3EAAAAAB) $display("FAIL fdiv_uft_mul: got %h want 3eaaaaab", fsn); else n_pass++;
    n_total++; if (lat !== FINV_LAT + FMUL_LAT + 2) $display("FAIL fdiv_lat: got %0d want %0d", lat, FINV_LAT + FMUL_LAT + 2); else n_pass++;
    n_total++; if (res !== 32'h40000000) $display("FAIL fdiv_res: got %h want 40000000", res); else n_pass++;
    n_total++; if (tag !== 5'd5) $display("FAIL fdiv_rd: got %0d want 5", tag); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      a = rnd_f(1'b0); b = rnd_f(1'b0);
      exp_r = m_mul(a, m_inv(b));
      run_op(OP_FDIV, a, b, 5'(i + 10), lat, nb, res, tag, e, fsn);
      n_total++; if (lat !== FINV_LAT + FMUL_LAT + 2 || res !== exp_r || tag !== 5'(i + 10) || e !== 1'b0)
        $display("FAIL fdiv_rand%0d: lat=%0d res=%h rd=%0d err=%b, want lat=%0d res=%h rd=%0d err=0", i, lat, res, tag, e, FINV_LAT + FMUL_LAT + 2, exp_r, i + 10);
      else n_pass++;
    end
  endtask

  task automatic test_fmul();
    int lat, nb;
    logic [31:0] res, fsn, a, b, exp_r;
    logic [4:0] tag;
    logic e;
    for (int i = 0; i < 5; i++) begin
      a = rnd_f(1'b0); b = rnd_f(1'b0);
      exp_r = m_mul(a, b);
      tick();
      run_op(OP_FMUL, a, b, 5'(i + 20), lat, nb, res, tag, e, fsn);
      n_total++; if (lat !== FMUL_LAT + 1 || res !== exp_r || tag !== 5'(i + 20) || e !== 1'b0)
        $display("FAIL fmul_rand%0d: lat=%0d res=%h rd=%0d err=%b, want lat=%0d res=%h rd=%0d err=0", i, lat, res, tag, e, FMUL_LAT + 1, exp_r, i + 20);
      else n_pass++;
    end
  endtask

  task automatic test_sqrt();
    int lat, nb, nd, first;
    logic [31:0] res, fsn, a, exp_r;
    logic [4:0] tag;
    logic e;
    tick();
    op = OP_SQRT; fs = 32'h41800000; ft = 32'h3F800000; rd_in = 5'd3; start = 1'b1;
    tick();
    op = OP_FMUL; fs = 32'h3F800000; rd_in = 5'd12;
    tick();
    start = 1'b0;
    nd = 0; first = -1;
    for (int k = 2; k <= 12; k++) begin
      if (done) begin
        nd++;
        if (first < 0) begin
          first = k - 1;
          res = result;
          tag = rd_out;
        end
      end
      tick();
    end
    n_total++; if (nd !== 1) $display("FAIL sqrt_one_done: saw %0d done, want 1", nd); else n_pass++;
    n_total++; if (first !== SQRT_LAT + 1) $display("FAIL sqrt_lat: got %0d want %0d", first, SQRT_LAT + 1); else n_pass++;
    n_total++; if (res !== 32'h40800000 || tag !== 5'd3) $display("FAIL sqrt_res: got %h rd=%0d want 40800000 rd=3", res, tag); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      a = rnd_f(1'b1);
      exp_r = m_sqrt(a);
      run_op(OP_SQRT, a, rnd_f(1'b0), 5'(i + 1), lat, nb, res, tag, e, fsn);
      n_total++; if (lat !== SQRT_LAT + 1 || res !== exp_r || tag !== 5'(i + 1))
        $display("FAIL sqrt_rand%0d: lat=%0d res=%h rd=%0d, want lat=%0d res=%h rd=%0d", i, lat, res, tag, SQRT_LAT + 1, exp_r, i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    int lat, nb;
    logic [31:0] res, fsn;
    logic [4:0] tag;
    logic e;
    tick();
    run_op(OP_BAD, rnd_f(1'b0), rnd_f(1'b0), 5'd21, lat, nb, res, tag, e, fsn);
    n_total++; if (lat !== 1 || e !== 1'b1) $display("FAIL illegal_pulse: lat=%0d err=%b want lat=1 err=1", lat, e); else n_pass++;
    n_total++; if (res !== 32'h0) $display("FAIL illegal_res: got %h want 0", res); else n_pass++;
    n_total++; if (nb !== 0 || busy !== 1'b0) $display("FAIL illegal_busy: busy cycles %0d want 0", nb); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL illegal_one_cycle: done=%b err=%b want 0/0", done, err); else n_pass++;
  endtask

  task automatic test_flush();
    int lat, nb, nd;
    logic [31:0] res, fsn, a, b, prior;
    logic [4:0] tag;
    logic e;
    a = rnd_f(1'b0); b = rnd_f(1'b0);
    prior = m_mul(a, b);
    run_op(OP_FMUL, a, b, 5'd4, lat, nb, res, tag, e, fsn);
    op = OP_FDIV; fs = rnd_f(1'b0); ft = rnd_f(1'b0); rd_in = 5'd9; start = 1'b1;
    tick();
    start = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_idle: busy=%b want 0", busy); else n_pass++;
    nd = done ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) nd++;
    end
    n_total++; if (nd !== 0) $display("FAIL flush_no_done: saw %0d done, want 0", nd); else n_pass++;
    n_total++; if (result !== prior || rd_out !== 5'd9) $display("FAIL flush_hold: res=%h rd=%0d want res=%h rd=9", result, rd_out, prior); else n_pass++;
    op = OP_FMUL; rd_in = 5'd17; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || busy) nd++;
      tick();
    end
    n_total++; if (nd !== 0 || rd_out !== 5'd9) $display("FAIL flush_drops_start: activity=%0d rd=%0d want 0 and rd=9", nd, rd_out); else n_pass++;
    a = rnd_f(1'b0); b = rnd_f(1'b0);
    run_op(OP_FMUL, a, b, 5'd30, lat, nb, res, tag, e, fsn);
    n_total++; if (lat !== FMUL_LAT + 1 || res !== m_mul(a, b) || tag !== 5'd30)
      $display("FAIL flush_recover: lat=%0d res=%h rd=%0d want lat=%0d res=%h rd=30", lat, res, tag, FMUL_LAT + 1, m_mul(a, b));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    logic [31:0] res, fsn, a, b;
    logic [4:0] tag;
    logic e;
    tick();
    run_op(OP_FMUL, rnd_f(1'b0), rnd_f(1'b0), 5'd1, lat, nb, res, tag, e, fsn);
    n_total++; if (lat !== FMUL_LAT + 1) $display("FAIL b2b_first_lat: got %0d want %0d", lat, FMUL_LAT + 1); else n_pass++;
    a = rnd_f(1'b0); b = rnd_f(1'b0);
    run_op(OP_FMUL, a, b, 5'd2, lat, nb, res, tag, e, fsn);
    n_total++; if (lat + 1 !== FMUL_LAT + 2) $display("FAIL b2b_gap: done spacing %0d want %0d", lat + 1, FMUL_LAT + 2); else n_pass++;
    n_total++; if (res !== m_mul(a, b) || tag !== 5'd2) $display("FAIL b2b_second: res=%h rd=%0d want res=%h rd=2", res, tag, m_mul(a, b)); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fdiv();
    test_fmul();
    test_sqrt();
    test_illegal();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
